inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/FETCH_PKG.sv | 16 +
 rtl/inst_fifo.sv | 68 ++++++
 rtl/inst_fetch.sv | 112 +++++++++++
 tb/tb_inst_fetch.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/FETCH_PKG.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package FETCH_PKG;

  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_DEF  = 4;
  localparam int INST_W     = 20;

  localparam logic [INST_W-1:0] NOP_INST = 20'h00000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fifo.sv
// Instruction queue: power-of-two ring buffer with push/pop/clear and occupancy count.
module inst_fifo
  import FETCH_PKG::*;
#(
  parameter int WIDTH = INST_W + ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;

  // Pointer and occupancy next-state; clear wins over push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the head is only looked at when count is nonzero.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, ROM read issue, jump redirect and the decode-facing queue.
module inst_fetch
  import FETCH_PKG::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              nRESET,
  output logic [ADDR_W-1:0] ROM_ADDR,
  output logic              ROM_RD,
  input  logic [INST_W-1:0] ROM_DATA,
  input  logic              JUMP,
  input  logic [ADDR_W-1:0] JUMP_ADDR,
  input  logic              STALL,
  output logic [INST_W-1:0] INST,
  output logic              INST_VALID,
  output logic [ADDR_W-1:0] INST_PC
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INST_W + ADDR_W;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;

  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occupancy;
  logic [EW-1:0] fifo_head;
  logic          push, pop;

  // State register.
  always_ff @(posedge CLK) begin
    if (!nRESET) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: a jump always redirects, every other state settles into RUN.
  always_comb begin
    state_d = state_q;
    if (JUMP) begin
      state_d = REDIR;
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        REDIR:   state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: issue only while the queue plus the pending word still has room.
  always_comb begin
    occupancy = fifo_count + CW'(inflight_q);
    ROM_RD    = nRESET && (state_q == RUN) && !JUMP && (occupancy < DEPTH_C);
  end

  // PC and in-flight tracking next-state; jump discards the pending word.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (JUMP) begin
      pc_d = JUMP_ADDR;
    end else if (ROM_RD) begin
      pc_d          = pc_q + PC_ONE;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
  end

  // PC and in-flight registers.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign push = inflight_q && !JUMP;
  assign pop  = (fifo_count != '0) && !STALL && !JUMP;

  inst_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (nRESET),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (JUMP),
    .data_i  ({inflight_pc_q, ROM_DATA}),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign ROM_ADDR   = pc_q;
  assign INST_VALID = (fifo_count != '0);
  assign INST       = INST_VALID ? fifo_head[INST_W-1:0] : NOP_INST;
  assign INST_PC    = INST_VALID ? fifo_head[EW-1:INST_W] : '0;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized and directed bench for inst_fetch against a queue-level reference model.
module tb_inst_fetch;

  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          nRESET = 1'b0;
  logic          JUMP = 1'b0;
  logic          STALL = 1'b0;
  logic [AW-1:0] JUMP_ADDR = '0;
  logic [19:0]   ROM_DATA = '0;
  logic          ROM_RD, INST_VALID;
  logic [AW-1:0] ROM_ADDR, INST_PC;
  logic [19:0]   INST;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  inst_fetch #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .nRESET     (nRESET),
    .ROM_ADDR   (ROM_ADDR),
    .ROM_RD     (ROM_RD),
    .ROM_DATA   (ROM_DATA),
    .JUMP       (JUMP),
    .JUMP_ADDR  (JUMP_ADDR),
    .STALL      (STALL),
    .INST       (INST),
    .INST_VALID (INST_VALID),
    .INST_PC    (INST_PC)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the decode queue as a plain SV queue of (pc, word) pairs.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [19:0]   data;
  } ent_t;

  ent_t          mq[$];
  int            m_mode = 0;      // 0 idle, 1 run, 2 redirect
  logic [AW-1:0] m_pc   = '0;
  logic [AW-1:0] m_ipc  = '0;
  bit            m_infl = 1'b0;
  bit            seen_rst = 1'b0;

  function automatic logic [19:0] rom_word(input logic [AW-1:0] a);
    return 20'h10000 + 20'(a);
  endfunction

  // One clock: drive inputs at negedge, compare outputs, advance model, then ROM answers.
  task automatic cycle(input bit rst_n, input bit jmp, input logic [AW-1:0] ja, input bit stl);
    bit   exp_rd;
    ent_t e;
    @(negedge CLK);
    nRESET    = rst_n;
    JUMP      = jmp;
    JUMP_ADDR = ja;
    STALL     = stl;
    #1;
    exp_rd = rst_n && (m_mode == 1) && !jmp && ((mq.size() + int'(m_infl)) < DEPTH);
    check_val("rom_rd", 32'(ROM_RD), 32'(exp_rd));
    if (rst_n && seen_rst) begin
      check_val("rom_addr",   32'(ROM_ADDR),   32'(m_pc));
      check_val("inst_valid", 32'(INST_VALID), 32'(mq.size() != 0));
      check_val("inst",    32'(INST),    (mq.size() != 0) ? 32'(mq[0].data) : 32'd0);
      check_val("inst_pc", 32'(INST_PC), (mq.size() != 0) ? 32'(mq[0].pc)   : 32'd0);
    end
    if (seen_rst)
      check_val("no_push_full", 32'(dut.push && (int'(dut.fifo_count) == DEPTH)), 32'd0);
    if (!rst_n) begin
      m_mode = 0; m_pc = '0; m_infl = 1'b0; mq.delete(); seen_rst = 1'b1;
    end else if (jmp) begin
      m_mode = 2; m_pc = ja; m_infl = 1'b0; mq.delete();
    end else begin
      if (mq.size() != 0 && !stl) void'(mq.pop_front());
      if (m_infl) begin
        e.pc = m_ipc; e.data = ROM_DATA;
        mq.push_back(e);
      end
      if (exp_rd) begin
        m_ipc = m_pc; m_pc = m_pc + AW'(1); m_infl = 1'b1;
      end else begin
        m_infl = 1'b0;
      end
      m_mode = 1;
    end
    @(posedge CLK);
    #1;
    ROM_DATA = exp_rd ? rom_word(m_ipc) : 20'($urandom);
  endtask

  logic [AW-1:0] wrap_seq [4];

  initial begin
    wrap_seq[0] = 10'h3FE; wrap_seq[1] = 10'h3FF; wrap_seq[2] = 10'h000; wrap_seq[3] = 10'h001;

    // Start-up fetch with no stall.
    repeat (2) cycle(0, 0, '0, 0);
    repeat (3) cycle(1, 0, '0, 0);
    check_val("start_inst",    32'(INST),    32'h10000);
    check_val("start_inst_pc", 32'(INST_PC), 32'd0);
    cycle(1, 0, '0, 0);
    check_val("start_inst2",    32'(INST),    32'h10001);
    check_val("start_inst_pc2", 32'(INST_PC), 32'd1);

    // Stall from reset: fill and stop, then one pop re-opens issue at address 4.
    cycle(0, 0, '0, 1);
    repeat (8) cycle(1, 0, '0, 1);
    check_val("full_count",  32'(dut.fifo_count), 32'd4);
    check_val("full_rd",     32'(ROM_RD),          32'd0);
    check_val("full_inst",   32'(INST),            32'h10000);
    cycle(1, 0, '0, 0);
    check_val("resume_rd",   32'(ROM_RD),   32'd1);
    check_val("resume_addr", 32'(ROM_ADDR), 32'd4);

    // Jump with a read in flight and the queue occupied.
    cycle(1, 0, '0, 1);
    cycle(1, 1, 10'h200, 1);
    check_val("jump_valid", 32'(INST_VALID), 32'd0);
    repeat (3) cycle(1, 0, '0, 0);
    check_val("jump_first_pc", 32'(INST_PC), 32'h200);

    // Address wrap at the top of program memory.
    cycle(1, 1, 10'h3FE, 0);
    repeat (3) cycle(1, 0, '0, 0);
    for (int i = 0; i < 4; i++) begin
      check_val("wrap_pc", 32'(INST_PC), 32'(wrap_seq[i]));
      cycle(1, 0, '0, 0);
    end

    // Mid-stream reset with queue partly full; reset also beats JUMP and STALL.
    repeat (3) cycle(1, 0, '0, 1);
    cycle(0, 1, 10'h155, 1);
    check_val("rst_valid", 32'(INST_VALID), 32'd0);
    check_val("rst_rd",    32'(ROM_RD),     32'd0);
    check_val("rst_addr",  32'(ROM_ADDR),   32'd0);
    check_val("rst_inst",  32'(INST),       32'd0);
    repeat (6) cycle(1, 0, '0, 0);

    // Jump coinciding with push and pop at count 1.
    cycle(1, 1, 10'h0AB, 0);
    check_val("jcp_count", 32'(dut.fifo_count), 32'd0);
    check_val("jcp_pc",    32'(ROM_ADDR),       32'h0AB);
    repeat (4) cycle(1, 0, '0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 100) != 0, ($urandom % 16) == 0, AW'($urandom), ($urandom % 3) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
